// File: rtl/temporal_neuron.sv
// temporal_neuron
//   Ramp-no-leak (RNL) temporal neuron. It integrates NUM_INPUTS spike lines
//   over one gamma cycle of TIME_PERIOD steps and reports its own firing step
//   in the same temporal code. TIME_PERIOD on out_time means "no spike".
//   The neuron owns the gamma-cycle counter and drives time_val back to the
//   upstream spike_generation stages, so both stages compare against one step.
//
//   Configuration macros:
//     TN_TIME_PERIOD              default for TIME_PERIOD (normally supplied
//                                 by internal_defines.vh; 8 if not defined)
//     TEMPORAL_NEURON_INHIBIT_EN  adds the inhibit input and a sticky
//                                 inhibited flag that suppresses firing
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   begin a gamma cycle (sampled only in IDLE)
//   in_spikes  in   [NUM_INPUTS] spike lines, level, sampled every RUN cycle
//   weights    in   [NUM_INPUTS*WEIGHT_W] unsigned weights, synapse i at
//                   [i*WEIGHT_W +: WEIGHT_W]; stable during RUN
//   threshold  in   [POT_W] firing threshold; stable during RUN
//   inhibit    in   (TEMPORAL_NEURON_INHIBIT_EN only) block firing
//   time_val   out  [TW] current time step
//   busy       out  high in RUN and DONE
//   out_spike  out  one-cycle pulse on the cycle after the threshold crossing
//   out_time   out  [TW] firing step, TIME_PERIOD if the neuron did not fire
//   out_valid  out  one-cycle pulse in DONE; out_time is final while high

`ifndef TN_TIME_PERIOD
`define TN_TIME_PERIOD 8
`endif

module temporal_neuron #(
    parameter int NUM_INPUTS  = 8,
    parameter int TIME_PERIOD = `TN_TIME_PERIOD,
    parameter int WEIGHT_W    = 3,
    parameter int TW          = $clog2(TIME_PERIOD) + 1,
    parameter int POT_W       = WEIGHT_W + $clog2(NUM_INPUTS) + $clog2(TIME_PERIOD) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_INPUTS-1:0]          in_spikes,
    input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
    input  logic [POT_W-1:0]               threshold,
`ifdef TEMPORAL_NEURON_INHIBIT_EN
    input  logic                           inhibit,
`endif
    output logic [TW-1:0]                  time_val,
    output logic                           busy,
    output logic                           out_spike,
    output logic [TW-1:0]                  out_time,
    output logic                           out_valid
);

    localparam logic [TW-1:0] LAST_STEP = TW'(TIME_PERIOD - 1);
    localparam logic [TW-1:0] NO_SPIKE  = TW'(TIME_PERIOD);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [NUM_INPUTS-1:0]   arrived;
    logic [NUM_INPUTS-1:0]   arrived_next;
    logic [POT_W-1:0]        potential;
    logic [POT_W-1:0]        contrib;
    logic [POT_W:0]          pot_sum;
    logic [POT_W-1:0]        pot_next;
    logic                    fired;
    logic                    fire_enable;
    logic                    fire_now;

`ifdef TEMPORAL_NEURON_INHIBIT_EN
    logic inhibited;
    // Inhibit seen on the same edge as a crossing already blocks that fire.
    assign fire_enable = !(inhibited || inhibit);
`else
    assign fire_enable = 1'b1;
`endif

    // NOTE: every variable gets a default before the loop/branches so the
    // combinational block cannot infer a latch.
    always_comb begin
        // A line counts from its first high cycle to the end of the gamma
        // cycle: the ramp keeps adding its weight every step.
        arrived_next = arrived | in_spikes;
        contrib      = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (arrived_next[i])
                contrib = contrib + POT_W'(weights[i*WEIGHT_W +: WEIGHT_W]);
        end
        // One extra bit catches the carry so the potential saturates
        // instead of wrapping.
        pot_sum  = {1'b0, potential} + {1'b0, contrib};
        pot_next = pot_sum[POT_W] ? {POT_W{1'b1}} : pot_sum[POT_W-1:0];
        fire_now = (pot_next >= threshold) && !fired && fire_enable;
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            time_val  <= '0;
            busy      <= 1'b0;
            out_spike <= 1'b0;
            out_valid <= 1'b0;
            out_time  <= NO_SPIKE;
            potential <= '0;
            fired     <= 1'b0;
            arrived   <= '0;
`ifdef TEMPORAL_NEURON_INHIBIT_EN
            inhibited <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; only the cycle that sets them holds them.
            out_spike <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        time_val  <= '0;
                        potential <= '0;
                        fired     <= 1'b0;
                        arrived   <= '0;
                        out_time  <= NO_SPIKE;
`ifdef TEMPORAL_NEURON_INHIBIT_EN
                        inhibited <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    arrived   <= arrived_next;
                    potential <= pot_next;
`ifdef TEMPORAL_NEURON_INHIBIT_EN
                    inhibited <= inhibited | inhibit;
`endif
                    if (fire_now) begin
                        fired     <= 1'b1;
                        out_time  <= time_val;
                        out_spike <= 1'b1;
                    end
                    // time_val holds on the last step so it never shows
                    // TIME_PERIOD while busy.
                    if (time_val == LAST_STEP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        time_val  <= time_val + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temporal_neuron.sv
// tb_temporal_neuron
//   Self-checking bench for temporal_neuron with NUM_INPUTS=4, TIME_PERIOD=8,
//   WEIGHT_W=3. Directed records carry hand-derived firing steps; random
//   records get theirs from a ramp model built on arrival times.
//   Build with +define+TEMPORAL_NEURON_INHIBIT_EN to exercise inhibit.

module tb_temporal_neuron;

    localparam int N   = 4;
    localparam int TP  = 8;
    localparam int WW  = 3;
    localparam int TW  = 4;
    localparam int PW  = 9;
    localparam int PMAX = (1 << PW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N-1:0]    in_spikes;
    logic [N*WW-1:0] weights;
    logic [PW-1:0]   threshold;
`ifdef TEMPORAL_NEURON_INHIBIT_EN
    logic            inhibit;
`endif
    logic [TW-1:0]   time_val;
    logic            busy;
    logic            out_spike;
    logic [TW-1:0]   out_time;
    logic            out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    temporal_neuron #(
        .NUM_INPUTS (N),
        .TIME_PERIOD(TP),
        .WEIGHT_W   (WW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_spikes(in_spikes),
        .weights  (weights),
        .threshold(threshold),
`ifdef TEMPORAL_NEURON_INHIBIT_EN
        .inhibit  (inhibit),
`endif
        .time_val (time_val),
        .busy     (busy),
        .out_spike(out_spike),
        .out_time (out_time),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                 name;
        logic [N*WW-1:0]       w;
        logic [PW-1:0]         thr;
        logic [TP-1:0][N-1:0]  pat;          // pat[t] = in_spikes at step t
        int                    restart_step; // -1: no start pulse during RUN
        int                    inh_step;     // -1: no inhibit
        int                    exp_time;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic [N*WW-1:0] w,
                                input int thr, input int restart_step,
                                input int inh_step, input int exp_time);
        vec_t v;
        v.name         = name;
        v.w            = w;
        v.thr          = PW'(thr);
        v.pat          = '0;
        v.restart_step = restart_step;
        v.inh_step     = inh_step;
        v.exp_time     = exp_time;
        return v;
    endfunction

    // Ramp model: an input arriving at step a adds w*(t-a+1) by step t.
    function automatic int model_fire(input vec_t v);
        int arr[N];
        int pot;
        for (int i = 0; i < N; i++) begin
            arr[i] = TP;
            for (int t = TP - 1; t >= 0; t--)
                if (v.pat[t][i]) arr[i] = t;
        end
        for (int t = 0; t < TP; t++) begin
            pot = 0;
            for (int i = 0; i < N; i++)
                if (arr[i] <= t) pot += int'(v.w[i*WW +: WW]) * (t - arr[i] + 1);
            if (pot > PMAX) pot = PMAX;
            if (v.inh_step >= 0 && t >= v.inh_step) continue;
            if (pot >= int'(v.thr)) return t;
        end
        return TP;
    endfunction

    task automatic run_gamma(input vec_t v);
        int spikes;
        int spike_at;
        int valids;
        spikes   = 0;
        spike_at = -1;
        valids   = 0;
        weights   = v.w;
        threshold = v.thr;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < TP; k++) begin
            check({v.name, " time_val"}, int'(time_val), k);
            if (out_spike) begin spikes++; spike_at = k - 1; end
            if (out_valid) valids++;
            in_spikes = v.pat[k];
            start     = (k == v.restart_step);
`ifdef TEMPORAL_NEURON_INHIBIT_EN
            inhibit   = (k == v.inh_step);
`endif
            @(negedge clk);
        end
        // DONE cycle
        start     = 1'b0;
        in_spikes = '0;
`ifdef TEMPORAL_NEURON_INHIBIT_EN
        inhibit   = 1'b0;
`endif
        if (out_spike) begin spikes++; spike_at = TP - 1; end
        check({v.name, " out_valid in DONE"}, int'(out_valid), 1);
        check({v.name, " out_time"}, int'(out_time), v.exp_time);
        check({v.name, " out_valid during RUN"}, valids, 0);
        check({v.name, " spike count"}, spikes, (v.exp_time < TP) ? 1 : 0);
        if (v.exp_time < TP)
            check({v.name, " spike step"}, spike_at, v.exp_time);
        @(negedge clk);
        check({v.name, " out_valid after DONE"}, int'(out_valid), 0);
        check({v.name, " busy after DONE"}, int'(busy), 0);
        if (v.restart_step >= 0) begin
            @(negedge clk);
            check({v.name, " restart not queued"}, int'(busy), 0);
        end
    endtask

    initial begin
        vec_t v;
        int   valids;

        rst       = 1'b1;
        start     = 1'b0;
        in_spikes = '0;
        weights   = '0;
        threshold = '0;
`ifdef TEMPORAL_NEURON_INHIBIT_EN
        inhibit   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset time_val", int'(time_val), 0);
        check("reset busy", int'(busy), 0);
        check("reset out_spike", int'(out_spike), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_time", int'(out_time), TP);
        rst = 1'b0;

        // Directed records
        v = mk("w7_late", 12'hFFF, 7, -1, -1, 2);
        v.pat[2] = 4'b0001;
        tbl.push_back(v);
        v = mk("w1_nofire", 12'h249, 100, -1, -1, TP);
        v.pat[0] = 4'b1111;
        tbl.push_back(v);
        v = mk("pulse_latch", 12'h002, 6, -1, -1, 3);
        v.pat[1] = 4'b0001;
        tbl.push_back(v);
        v = mk("thr0_restart", 12'h000, 0, 3, -1, 0);
        tbl.push_back(v);
        v = mk("fire_last", 12'h001, 8, -1, -1, 7);
        v.pat[0] = 4'b0001;
        tbl.push_back(v);
        v = mk("just_miss", 12'h001, 9, -1, -1, TP);
        v.pat[0] = 4'b0001;
        tbl.push_back(v);
        v = mk("saturate_full", 12'hFFF, 511, -1, -1, TP);
        v.pat = '1;
        tbl.push_back(v);
`ifdef TEMPORAL_NEURON_INHIBIT_EN
        v = mk("inhibit_block", 12'h002, 6, -1, 1, TP);
        v.pat[1] = 4'b0001;
        tbl.push_back(v);
        v = mk("inhibit_late", 12'hFFF, 7, -1, 5, 2);
        v.pat[2] = 4'b0001;
        tbl.push_back(v);
        v = mk("inhibit_same_edge", 12'h002, 6, -1, 3, TP);
        v.pat[1] = 4'b0001;
        tbl.push_back(v);
`endif

        // Random records, expected step from the ramp model
        for (int r = 0; r < 12; r++) begin
            v = mk($sformatf("rand%0d", r), N*WW'($urandom),
                   int'($urandom_range(0, 150)), -1, -1, 0);
            for (int t = 0; t < TP; t++)
                for (int i = 0; i < N; i++)
                    v.pat[t][i] = ($urandom_range(0, 5) == 0);
`ifdef TEMPORAL_NEURON_INHIBIT_EN
            if ($urandom_range(0, 2) == 0) v.inh_step = int'($urandom_range(0, TP - 1));
`endif
            v.exp_time = model_fire(v);
            tbl.push_back(v);
        end

        foreach (tbl[j]) run_gamma(tbl[j]);

        // Reset in the middle of RUN: fires at t=0, then reset at t=4.
        weights   = 12'hFFF;
        threshold = PW'(7);
        in_spikes = 4'b1111;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun time_val before reset", int'(time_val), 4);
        check("midrun out_time before reset", int'(out_time), 0);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        in_spikes = '0;
        check("midrun reset time_val", int'(time_val), 0);
        check("midrun reset busy", int'(busy), 0);
        check("midrun reset out_time", int'(out_time), TP);
        check("midrun reset out_valid", int'(out_valid), 0);
        valids = 0;
        repeat (TP + 2) begin
            @(negedge clk);
            if (out_valid) valids++;
        end
        check("midrun no out_valid after reset", valids, 0);
        v = mk("after_reset", 12'hFFF, 7, -1, -1, 2);
        v.pat[2] = 4'b0100;
        run_gamma(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/temporal_neuron.md
Name: temporal_neuron

Overview:
- Downstream consumer of spike_generation: one ramp-no-leak (RNL) temporal neuron that integrates NUM_INPUTS spike lines over one gamma cycle of TIME_PERIOD steps.
- Owns the gamma-cycle time counter. Drives time_val back to the upstream spike_generation instances, so both stages compare against the same step.
- Reports its own output spike time in the same temporal code, with TIME_PERIOD meaning "no spike".

Parameters:
- NUM_INPUTS, 8, number of input spike lines (synapses).
- TIME_PERIOD, `time_period (from internal_defines.vh), number of time steps per gamma cycle.
- WEIGHT_W, 3, unsigned weight width per synapse.
- TW, $clog2(TIME_PERIOD)+1, time-value width; matches spike_generation time ports.
- POT_W, WEIGHT_W+$clog2(NUM_INPUTS)+$clog2(TIME_PERIOD)+1, body-potential width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a gamma cycle; sampled only in IDLE.
- in_spikes  in  NUM_INPUTS  input spike lines; level, sampled every RUN cycle.
- weights  in  NUM_INPUTS*WEIGHT_W  flattened unsigned weights; bits [i*WEIGHT_W +: WEIGHT_W] are synapse i. Must be held stable during RUN.
- threshold  in  POT_W  firing threshold; must be held stable during RUN.
- time_val  out  TW  current time step.
- busy  out  1  high in RUN and DONE.
- out_spike  out  1  one-cycle pulse on the cycle after the threshold crossing.
- out_time  out  TW  step at which the neuron fired; TIME_PERIOD if it did not fire.
- out_valid  out  1  one-cycle pulse in DONE; out_time is final while it is high.

Behaviour:
- Reset: state=IDLE. time_val, out_spike, out_valid, busy = 0. out_time=TIME_PERIOD. Potential, fired flag and arrival latches = 0. Reset mid-RUN or mid-DONE aborts the cycle with no out_valid.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE -> RUN on start=1:
  - time_val<=0; potential, fired and arrival latches cleared; out_time<=TIME_PERIOD.
- RUN, each clock edge at step t=time_val:
  - arrived_next = arrived | in_spikes. A line counts from its first high cycle to the end of the gamma cycle; later toggles are ignored.
  - contrib = sum of weights[i] for every set bit of arrived_next. Zero-extend to POT_W before adding.
  - pot_next = potential + contrib, saturating at 2^POT_W-1 (never wraps).
  - If pot_next >= threshold (unsigned) and fired=0: fired<=1, out_time<=t, out_spike<=1 for exactly one cycle.
  - At most one fire per gamma cycle.
  - threshold=0 fires at t=0 even with no inputs.
  - If t==TIME_PERIOD-1: next state is DONE and time_val holds. Otherwise time_val<=t+1.
  - A fire at t=TIME_PERIOD-1 is legal: out_time=TIME_PERIOD-1, and out_spike and out_valid coincide in DONE.
- DONE: out_valid=1 for one cycle, then IDLE. start is ignored in DONE.
- start while busy is ignored; no queuing.
- Latency: start to out_valid is TIME_PERIOD+1 cycles. out_spike rises t+2 cycles after start.
- time_val is never TIME_PERIOD during RUN.

Optional Feature:
- Macro: TEMPORAL_NEURON_INHIBIT_EN.
- Defined:
  - Adds input port inhibit (1 bit).
  - inhibit=1 in any RUN cycle sets a sticky inhibited flag, cleared only at IDLE->RUN or by reset.
  - While inhibited, or on the same edge inhibit is first seen, no fire may occur; potential keeps integrating.
  - inhibit arriving on the same edge as a threshold crossing wins: no fire.
  - A fire that already happened is not revoked.
- Undefined: no port, no flag; behaviour exactly as above.

Test Plan:
- Common setup: NUM_INPUTS=4, TIME_PERIOD=8, WEIGHT_W=3.
- Weights all 7, threshold=7, in_spikes[0] high only at t=2 -> out_spike in the cycle after t=2; out_valid 9 cycles after start with out_time=2.
- weights={1,1,1,1}, threshold=100, all inputs high at t=0 -> potential ends at 32; out_spike never asserts; out_time=8 with out_valid.
- w0=2, others 0, threshold=6, in_spikes[0] pulses 1 cycle at t=1 -> potential 2,4,6 at t=1,2,3; fire at out_time=3 (arrival latched after pulse drops).
- rst during RUN at t=4 -> next cycle: IDLE, time_val=0, busy=0, out_time=8, no out_valid. A following start gives a fresh cycle with time_val 0..7.
- threshold=0, start re-asserted during RUN -> fires out_time=0; the re-start is ignored; exactly one out_valid.
- TEMPORAL_NEURON_INHIBIT_EN, scenario 3 with inhibit pulsed at t=1 -> no out_spike; out_time=8.
